// File: rtl/instr_encode_loader.sv
// Instruction encoder and loader. It accepts RV32I field bundles, packs each into a 32-bit
// instruction word, and writes the words one at a time to consecutive word addresses of
// instruction memory, starting from a base address.
module instr_encode_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] imm,
    input  logic        last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        last_q;
    logic [15:0] count_q;
    logic        err_q;

    logic [31:0] enc_d;
    logic        fmt_legal_d;
    logic        is_shift_imm;

    // Immediate shifts carry the shift type in bit 30 and take only a 5-bit shift amount.
    assign is_shift_imm = (opcode == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    always_comb begin
        enc_d       = 32'd0;
        fmt_legal_d = 1'b1;
        case (fmt)
            FMT_R: enc_d = {(funct7_5 ? 7'b0100000 : 7'b0000000), rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (is_shift_imm)
                    enc_d = {1'b0, funct7_5, 5'b00000, imm[4:0], rs1, funct3, rd, opcode};
                else
                    enc_d = {imm[11:0], rs1, funct3, rd, opcode};
            end
            FMT_S: enc_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: enc_d = {imm[31:12], rd, opcode};
            FMT_J: enc_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: fmt_legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            last_q  <= 1'b0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= {base_addr[31:2], 2'b00};
                        count_q <= 16'd0;
                        err_q   <= 1'b0;
                        state_q <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        if (fmt_legal_d) begin
                            wdata_q <= enc_d;
                            last_q  <= last;
                            state_q <= ST_WRITE;
                        end else begin
                            // An illegal bundle is dropped, but its last flag still ends the session.
                            err_q <= 1'b1;
                            if (last)
                                state_q <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack) begin
                        addr_q <= addr_q + 32'd4;
                        if (count_q != 16'hFFFF)
                            count_q <= count_q + 16'd1;
                        state_q <= last_q ? ST_DONE : ST_ACCEPT;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Every output decodes directly from registered state, so a reset takes effect at once.
    assign in_ready  = (state_q == ST_ACCEPT);
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed test of instr_encode_loader, checked against hand-encoded instruction words.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic [31:0] imm = 32'd0;
    logic        last = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    instr_encode_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7_5(funct7_5),
        .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
        $display("start base=%h busy=%0b in_ready=%0b", base, busy, in_ready);
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic f75, input logic [31:0] im, input logic lst);
        chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
        funct7_5 = f75; imm = im; last = lst; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        $display("send fmt=%0d op=%h imm=%h last=%0b", f, op, im, lst);
    endtask

    // Checks the pending write, holding off mem_ack for ack_delay cycles first.
    task automatic expect_write(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                                input int ack_delay);
        for (int k = 0; k <= ack_delay; k++) begin
            chk({tag, "_we"},    {31'd0, mem_we},   32'd1);
            chk({tag, "_addr"},  mem_addr,          ea);
            chk({tag, "_data"},  mem_wdata,         ed);
            chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
            if (k < ack_delay) @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        $display("write %s addr=%h data=%h", tag, mem_addr, mem_wdata);
    endtask

    task automatic expect_done(input string tag, input logic [15:0] ecount);
        chk({tag, "_done"},  {31'd0, done},  32'd1);
        chk({tag, "_count"}, {16'd0, count}, {16'd0, ecount});
        start = 1'b1;  // start while done is high must be ignored
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_off"}, {31'd0, done},     32'd0);
        chk({tag, "_idle"},     {31'd0, busy},     32'd0);
        chk({tag, "_no_acc"},   {31'd0, in_ready}, 32'd0);
        $display("done %s count=%0d", tag, count);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_cnt",  {16'd0, count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // addi x1,x0,5
        do_start(32'h100);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
        expect_write("addi", 32'h100, 32'h00500093, 0);
        expect_done("t1", 16'd1);

        // add / sub; base low bits forced to zero
        do_start(32'h203);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        expect_write("add", 32'h200, 32'h002081B3, 0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b1);
        expect_write("sub", 32'h204, 32'h402081B3, 0);
        expect_done("t2", 16'd2);

        // S/B/J/U plus immediate shifts, first write stalled 5 cycles
        do_start(32'h1000);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8, 1'b0);
        expect_write("sw", 32'h1000, 32'h0020A423, 5);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        expect_write("beq", 32'h1004, 32'hFE208EE3, 0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0);
        expect_write("jal", 32'h1008, 32'h008000EF, 0);
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'd3, 1'b0);
        expect_write("slli", 32'h100C, 32'h00311093, 0);
        send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'h0000_0FFF, 1'b0);
        expect_write("srai", 32'h1010, 32'h41F15093, 2);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1);
        expect_write("lui", 32'h1014, 32'h123452B7, 0);
        expect_done("t3", 16'd6);

        // Illegal format mid-session, then address wrap
        do_start(32'hFFFF_FFFC);
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        chk("ill_err",   {31'd0, err},      32'd1);
        chk("ill_we",    {31'd0, mem_we},   32'd0);
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        chk("ill_cnt",   {16'd0, count},    32'd0);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        expect_write("wrap0", 32'hFFFF_FFFC, 32'h00500093, 0);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        expect_write("wrap1", 32'h0000_0000, 32'hFFF00113, 0);
        expect_done("t4", 16'd2);
        chk("err_sticky", {31'd0, err}, 32'd1);
        do_start(32'h40);
        chk("err_clear", {31'd0, err}, 32'd0);

        // Illegal format carrying last ends the session with no write
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
        chk("ill_last_err", {31'd0, err}, 32'd1);
        expect_done("t5", 16'd0);

        // Reset during WRITE abandons the write
        do_start(32'h300);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we",   {31'd0, mem_we}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_data", mem_wdata, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_we",   {31'd0, mem_we}, 32'd0);
            chk("post_rst_busy", {31'd0, busy},   32'd0);
        end
        mem_ack = 1'b0;
        do_start(32'h300);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1);
        expect_write("resume", 32'h300, 32'h00500093, 0);
        expect_done("t6", 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
